char_scroll_ctrl: RTL and testbench

Sequencer that sits between the serial character receiver and the 5x7 character ROM. It buffers incoming ASCII codes in a small FIFO and issues one ROM lookup per character. It then streams the 35-bit bitmap out as 7-bit columns, one per scroll `tick`, inserting blank gap columns between characters. Downstream, the column shifter of the LED matrix consumes `col_out`/`col_valid`.

---
 rtl/char_scroll_ctrl_if.sv | 23 ++
 rtl/char_scroll_ctrl.sv | 142 ++++++++++++++
 tb/tb_char_scroll_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/char_scroll_ctrl_if.sv
// Character-in / ROM lookup / column-out signal bundle for char_scroll_ctrl.
// The slave side is the controller; the master side is the receiver, ROM and column shifter.
interface char_scroll_ctrl_if;
    logic [6:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic        tick;
    logic [6:0]  rom_addr;
    logic [34:0] rom_data;
    logic [6:0]  col_out;
    logic        col_valid;
    logic        busy;

    modport master (
        output char_in, char_valid, tick, rom_data,
        input  char_ready, rom_addr, col_out, col_valid, busy
    );

    modport slave (
        input  char_in, char_valid, tick, rom_data,
        output char_ready, rom_addr, col_out, col_valid, busy
    );
endinterface

// File: rtl/char_scroll_ctrl.sv
// Buffers ASCII codes, fetches each 5x7 bitmap and scrolls it out one 7-bit column per tick; CHARCTRL_IDLE_FILL_EN scrolls BLANK_CHAR when starved.
// Latency: push to first SHIFT cycle is 4 cycles; a serviced tick gives col_out/col_valid one cycle later.
// Backpressure: char_ready is a registered not-full flag; ticks beyond one pending are dropped.
module char_scroll_ctrl #(
    parameter int         FIFO_DEPTH = 4,
    parameter int         GAP_COLS   = 1,
    parameter logic [6:0] BLANK_CHAR = 7'd32
) (
    input  logic               clk,
    input  logic               rst,
    char_scroll_ctrl_if.slave  bus
);

`ifdef CHARCTRL_IDLE_FILL_EN
    localparam logic L_FILL = 1'b1;
`else
    localparam logic L_FILL = 1'b0;
`endif

    localparam int         AW     = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [2:0] L_LAST = 3'(4 + GAP_COLS);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LATCH, S_SHIFT} state_t;

    state_t      r_state, w_next;
    logic [6:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0] r_count, w_count_next;
    logic        r_rdy;
    logic        w_push, w_pop, w_empty;
    logic [6:0]  w_head;
    logic [34:0] r_bitmap;
    logic [2:0]  r_col_idx;
    logic        r_tick_pend;
    logic        w_service;
    logic [6:0]  w_col;
    logic [6:0]  r_rom_addr, r_col_out;
    logic        r_col_valid;

    // Character FIFO; ready is computed from the next count so it never depends on this cycle's pop.
    assign w_push       = bus.char_valid && r_rdy;
    assign w_empty      = (r_count == '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= bus.char_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdy    <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_next;
            r_rdy   <= (w_count_next != L_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_service = 1'b0;
        case (r_state)
            S_IDLE:  if (!w_empty || L_FILL) w_next = S_FETCH;
            S_FETCH: begin
                w_pop  = !w_empty;
                w_next = S_LATCH;
            end
            S_LATCH: w_next = S_SHIFT;
            S_SHIFT: begin
                w_service = r_tick_pend || bus.tick;
                if (w_service && (r_col_idx == L_LAST))
                    w_next = (!w_empty || L_FILL) ? S_FETCH : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_col = '0;
        case (r_col_idx)
            3'd0:    w_col = r_bitmap[34:28];
            3'd1:    w_col = r_bitmap[27:21];
            3'd2:    w_col = r_bitmap[20:14];
            3'd3:    w_col = r_bitmap[13:7];
            3'd4:    w_col = r_bitmap[6:0];
            default: w_col = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rom_addr  <= BLANK_CHAR;
            r_bitmap    <= '0;
            r_col_idx   <= '0;
            r_tick_pend <= 1'b0;
            r_col_out   <= '0;
            r_col_valid <= 1'b0;
        end else begin
            r_col_valid <= w_service;
            if (r_state == S_FETCH)
                r_rom_addr <= w_empty ? BLANK_CHAR : w_head;
            if (r_state == S_LATCH) begin
                r_bitmap  <= bus.rom_data;
                r_col_idx <= '0;
            end
            if (w_service) begin
                r_col_out <= w_col;
                if (r_col_idx != L_LAST)
                    r_col_idx <= r_col_idx + 3'd1;
            end
            // A tick landing on the cycle the pending flag is serviced stays pending for the next cycle.
            if (r_state == S_SHIFT)
                r_tick_pend <= r_tick_pend && bus.tick;
            else
                r_tick_pend <= r_tick_pend || bus.tick;
        end
    end

    assign bus.char_ready = r_rdy;
    assign bus.rom_addr   = r_rom_addr;
    assign bus.col_out    = r_col_out;
    assign bus.col_valid  = r_col_valid;
    assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_char_scroll_ctrl.sv
// Directed bench for char_scroll_ctrl with a column scoreboard fed from a behavioural ROM.
module tb_char_scroll_ctrl;
    localparam int GAP = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    char_scroll_ctrl_if bus();

    char_scroll_ctrl #(
        .FIFO_DEPTH(4),
        .GAP_COLS(GAP),
        .BLANK_CHAR(7'd32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [34:0] rom_model(input logic [6:0] a);
        if (a == 7'd65)
            return 35'h7_1234_5678;
        return {a, ~a, a ^ 7'h55, a + 7'd3, a[3:0], a[6:4]};
    endfunction

    assign bus.rom_data = rom_model(bus.rom_addr);

    logic [6:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [6:0] c);
        logic [34:0] bm;
        bm = rom_model(c);
        for (int k = 0; k < 5; k++)
            exp_q.push_back(bm[34-7*k -: 7]);
        for (int g = 0; g < GAP; g++)
            exp_q.push_back(7'h00);
    endtask

    // One clock; outputs are sampled 1 time unit after the edge and checked against the scoreboard.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (bus.col_valid === 1'b1) begin
            if (exp_q.size() == 0)
                chk("col_unexpected", 35'(bus.col_valid), 35'd0);
            else
                chk("col_out", 35'(bus.col_out), 35'(exp_q.pop_front()));
        end
    endtask

    task automatic drain(input string tag);
        int cnt;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 400) begin
            bus.tick = (cnt % 3 == 0);
            cyc();
            cnt++;
        end
        bus.tick = 1'b0;
        cyc();
        cyc();
        chk(tag, 35'(exp_q.size()), 35'd0);
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: simulation did not reach summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ok;

        rst            = 1'b1;
        bus.char_valid = 1'b1;
        bus.char_in    = 7'd99;
        bus.tick       = 1'b0;
        cyc();
        cyc();
        chk("rst_char_ready", 35'(bus.char_ready), 35'd0);
        chk("rst_col_valid",  35'(bus.col_valid),  35'd0);
        chk("rst_col_out",    35'(bus.col_out),    35'd0);
        chk("rst_rom_addr",   35'(bus.rom_addr),   35'd32);
        chk("rst_busy",       35'(bus.busy),       35'd0);

        // Release with char_valid still high: ready must rise only after this edge.
        rst = 1'b0;
        cyc();
        bus.char_valid = 1'b0;
        chk("rel_char_ready", 35'(bus.char_ready), 35'd1);
        cyc();
        cyc();
        chk("rel_no_push_busy", 35'(bus.busy), 35'd0);
        chk("rel_rom_addr", 35'(bus.rom_addr), 35'd32);

        // Single character 'A'.
        bus.char_in    = 7'd65;
        bus.char_valid = 1'b1;
        chk("a_ready", 35'(bus.char_ready), 35'd1);
        cyc();
        bus.char_valid = 1'b0;
        push_exp(7'd65);
        cyc();
        chk("a_busy_fetch", 35'(bus.busy), 35'd1);
        cyc();
        chk("a_rom_addr", 35'(bus.rom_addr), 35'd65);
        cyc();
        for (int i = 0; i < 5 + GAP; i++) begin
            bus.tick = 1'b1;
            cyc();
            bus.tick = 1'b0;
            chk("a_col_valid", 35'(bus.col_valid), 35'd1);
            cyc();
            cyc();
        end
        chk("a_queue_empty", 35'(exp_q.size()), 35'd0);
`ifndef CHARCTRL_IDLE_FILL_EN
        chk("a_idle_busy", 35'(bus.busy), 35'd0);
`endif

        // Pending tick: ticks in FETCH, LATCH (dropped) and first SHIFT cycle.
        bus.char_in    = 7'd66;
        bus.char_valid = 1'b1;
        cyc();
        bus.char_valid = 1'b0;
        push_exp(7'd66);
        cyc();
        bus.tick = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("pend_col0_vld", 35'(bus.col_valid), 35'd1);
        bus.tick = 1'b0;
        cyc();
        chk("pend_col1_vld", 35'(bus.col_valid), 35'd1);
        cyc();
        chk("pend_dropped_a", 35'(bus.col_valid), 35'd0);
        cyc();
        chk("pend_dropped_b", 35'(bus.col_valid), 35'd0);
        chk("pend_remaining", 35'(exp_q.size()), 35'(3 + GAP));
        drain("pend_drain");

        // FIFO full: five back-to-back pushes accepted, the sixth blocked.
        bus.char_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.char_in = 7'(70 + i);
            ok = bus.char_ready;
            chk("full_accept", 35'(ok), 35'(i < 5));
            cyc();
            if (ok)
                push_exp(7'(70 + i));
        end
        for (int i = 0; i < 3; i++) begin
            chk("full_blocked", 35'(bus.char_ready), 35'd0);
            cyc();
        end
        bus.char_valid = 1'b0;
        drain("full_drain");
        chk("full_ready_after", 35'(bus.char_ready), 35'd1);

        // Reset in the middle of SHIFT with two characters queued.
        bus.char_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.char_in = 7'(80 + i);
            cyc();
        end
        bus.char_valid = 1'b0;
        push_exp(7'd80);
        cyc();
        for (int i = 0; i < 3; i++) begin
            bus.tick = 1'b1;
            cyc();
            bus.tick = 1'b0;
            cyc();
        end
        chk("mid_cols_left", 35'(exp_q.size()), 35'(2 + GAP));
        rst = 1'b1;
        exp_q.delete();
        cyc();
        rst = 1'b0;
        chk("mid_rst_busy",     35'(bus.busy),       35'd0);
        chk("mid_rst_rom_addr", 35'(bus.rom_addr),   35'd32);
        chk("mid_rst_ready",    35'(bus.char_ready), 35'd0);
        cyc();
        chk("mid_rel_ready", 35'(bus.char_ready), 35'd1);
        for (int i = 0; i < 10; i++) begin
            bus.tick = 1'b1;
            cyc();
            bus.tick = 1'b0;
            chk("mid_no_col", 35'(bus.col_valid), 35'd0);
            cyc();
        end
        chk("mid_idle_busy", 35'(bus.busy), 35'd0);

        // A fresh character must be the next one out; idle ticks left one pending.
        bus.char_in    = 7'd90;
        bus.char_valid = 1'b1;
        cyc();
        bus.char_valid = 1'b0;
        push_exp(7'd90);
        cyc();
        cyc();
        chk("post_rst_rom_addr", 35'(bus.rom_addr), 35'd90);
        drain("post_rst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
